// File: rtl/local_average_filter_v3.sv
// Running-mean filter: passes pixels through with the mean of the last 2*RADIUS values.
// Define LOCAL_AVG_ROUND_EN for round-half-up averaging instead of truncation.
module local_average_filter_v3 #(
    parameter int PIX_W  = 8,
    parameter int RADIUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W:0]   pixel,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic [PIX_W:0]   out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] local_average
);

    localparam int W     = 2 * RADIUS;
    localparam int SHIFT = $clog2(W);
    localparam int SUM_W = PIX_W + SHIFT;

    logic [W-1:0][PIX_W-1:0] win_q, win_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [PIX_W:0]          pix_q, pix_d;
    logic [PIX_W-1:0]        avg_q, avg_d;
    logic                    vld_q, vld_d;

    logic                    accept;
    logic                    sof;
    logic [PIX_W-1:0]        v;
    logic [PIX_W-1:0]        oldest;
    logic [SUM_W-1:0]        sum_upd;
    logic [PIX_W-1:0]        avg_upd;

    assign sof         = pixel[PIX_W];
    assign v           = pixel[PIX_W-1:0];
    assign oldest      = win_q[W-1];
    assign pixel_ready = !reset && (!vld_q || out_ready);
    assign accept      = pixel_valid && pixel_ready;

    assign sum_upd = sum_q
                   + {{SHIFT{1'b0}}, v}
                   - {{SHIFT{1'b0}}, oldest};

    // Half-up rounding adds the bit just below the quotient; never overflows.
`ifdef LOCAL_AVG_ROUND_EN
    assign avg_upd = sum_upd[SUM_W-1:SHIFT]
                   + {{(PIX_W-1){1'b0}}, sum_upd[SHIFT-1]};
`else
    assign avg_upd = sum_upd[SUM_W-1:SHIFT];
`endif

    always_comb begin
        win_d = win_q;
        sum_d = sum_q;
        pix_d = pix_q;
        avg_d = avg_q;
        vld_d = vld_q;
        if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
        if (accept) begin
            vld_d = 1'b1;
            pix_d = pixel;
            if (sof) begin
                win_d = {W{v}};
                sum_d = {v, {SHIFT{1'b0}}};
                avg_d = v;
            end else begin
                win_d = {win_q[W-2:0], v};
                sum_d = sum_upd;
                avg_d = avg_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            sum_q <= '0;
            pix_q <= '0;
            avg_q <= '0;
            vld_q <= 1'b0;
        end else begin
            win_q <= win_d;
            sum_q <= sum_d;
            pix_q <= pix_d;
            avg_q <= avg_d;
            vld_q <= vld_d;
        end
    end

    assign out_pixel     = pix_q;
    assign out_valid     = vld_q;
    assign local_average = avg_q;

endmodule

// File: tb/tb_local_average_filter_v3.sv
// Scoreboard bench for local_average_filter_v3 (PIX_W=8, RADIUS=2).
// Reference model keeps the last W pixel values and averages them arithmetically.
module tb_local_average_filter_v3;

    localparam int PIX_W  = 8;
    localparam int RADIUS = 2;
    localparam int W      = 2 * RADIUS;

    typedef struct {
        logic [PIX_W:0]   pix;
        logic [PIX_W-1:0] avg;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PIX_W:0]   pixel = '0;
    logic             pixel_valid = 1'b0;
    logic             pixel_ready;
    logic [PIX_W:0]   out_pixel;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PIX_W-1:0] local_average;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   model_win[W];

    local_average_filter_v3 #(
        .PIX_W (PIX_W),
        .RADIUS(RADIUS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel        (pixel),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .local_average(local_average)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_avg(input int s);
`ifdef LOCAL_AVG_ROUND_EN
        return (s + W / 2) / W;
`else
        return s / W;
`endif
    endfunction

    // Reference model: push expected beat on every accepted input
    always @(negedge clk) begin
        if (reset) begin
            foreach (model_win[i]) model_win[i] = 0;
        end else if (pixel_valid && pixel_ready) begin
            exp_t e;
            int   v;
            int   s;
            v = int'(pixel[PIX_W-1:0]);
            if (pixel[PIX_W]) begin
                foreach (model_win[i]) model_win[i] = v;
                e.avg = PIX_W'(v);
            end else begin
                for (int i = W - 1; i > 0; i--) model_win[i] = model_win[i-1];
                model_win[0] = v;
                s = 0;
                foreach (model_win[i]) s += model_win[i];
                e.avg = PIX_W'(ref_avg(s));
            end
            e.pix = pixel;
            sb.push_back(e);
        end
    end

    // Monitor: compare transferred beats, handshake rule and hold stability
    logic             prev_hold = 1'b0;
    logic             prev_rst  = 1'b1;
    logic [PIX_W:0]   prev_pix;
    logic [PIX_W-1:0] prev_avg;

    always @(negedge clk) begin
        chk("pixel_ready", int'(pixel_ready),
            int'(!reset && (!out_valid || out_ready)));
        if (prev_hold && !prev_rst) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_pixel", int'(out_pixel), int'(prev_pix));
            chk("hold_avg", int'(local_average), int'(prev_avg));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pixel", int'(out_pixel), int'(e.pix));
                chk("sb_avg", int'(local_average), int'(e.avg));
            end
        end
        if (reset) sb.delete();
        prev_hold = out_valid && !out_ready;
        prev_rst  = reset;
        prev_pix  = out_pixel;
        prev_avg  = local_average;
    end

    task automatic send(input logic sof, input logic [PIX_W-1:0] v);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        pixel       = {sof, v};
        pixel_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pixel", int'(out_pixel), 0);
        chk("rst_avg", int'(local_average), 0);
        chk("rst_ready", int'(pixel_ready), 0);
        reset = 1'b0;
    endtask

    initial begin
        int exp_lo;
        int exp_hi;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send(1'b1, 8'd100);
        chk("sof_valid", int'(out_valid), 1);
        chk("sof_pixel", int'(out_pixel), 9'h164);
        chk("sof_avg", int'(local_average), 100);
        send(1'b0, 8'd104);
        chk("ramp_104", int'(local_average), 101);
        send(1'b0, 8'd108);
        chk("ramp_108", int'(local_average), 103);
        send(1'b0, 8'd112);
        chk("ramp_112", int'(local_average), 106);

        do_reset();
`ifdef LOCAL_AVG_ROUND_EN
        exp_lo = 1;
        exp_hi = 21;
`else
        exp_lo = 0;
        exp_hi = 20;
`endif
        send(1'b0, 8'd2);
        chk("nosof_2", int'(local_average), exp_lo);
        send(1'b0, 8'd80);
        chk("nosof_80", int'(local_average), exp_hi);

        send(1'b0, 8'd10);
        send(1'b0, 8'd20);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", int'(pixel_ready), 0);
            chk("bp_pixel", int'(out_pixel), 20);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 8'd30);
        send(1'b0, 8'd40);
        send(1'b0, 8'd50);

        send(1'b1, 8'd200);
        send(1'b0, 8'd200);
        send(1'b0, 8'd200);
        send(1'b1, 8'd50);
        chk("refr_sof", int'(local_average), 50);
        send(1'b0, 8'd50);
        chk("refr_1", int'(local_average), 50);
        send(1'b0, 8'd50);
        chk("refr_2", int'(local_average), 50);

        do_reset();
        send(1'b0, 8'd80);
        chk("post_rst_80", int'(local_average), 20);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset       = ($urandom_range(0, 299) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            pixel_valid = ($urandom_range(0, 3) != 0);
            pixel       = {($urandom_range(0, 7) == 0),
                           PIX_W'($urandom)};
        end
        @(posedge clk);
        #1;
        reset       = 1'b0;
        pixel_valid = 1'b0;
        out_ready   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
